huff_tree_ctrl: RTL
===================

Name: huff_tree_ctrl

Overview:
- Sequential Huffman tree builder wrapped around the combinational 8-slot weight sorter.
- Captures 8 character weights, then runs 7 merge rounds; each round drives the sorter and consumes its sorted order.
- After the last round, emits the per-character code length and code bits.
- Sits between the frame input stage and the code serializer.

Parameters:
- NUM_CHAR, 8, number of characters and sorter slots; only 8 is supported.
- W_WIDTH, 5, weight width; matches the sorter key width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  high for exactly 8 contiguous cycles per frame.
- in_weight  in  5  weight of character k on the k-th in_valid cycle, k = 0..7.
- sort_character  out  32  to sorter; slot s in bits [4s+3:4s] holds a node id.
- sort_weight  out  40  to sorter; slot s in bits [5s+4:5s] holds that node's weight.
- sorted_character  in  32  from sorter; node ids ordered by ascending weight, slot 0 smallest.
- busy  out  1  high from the first in_valid cycle until the last out_valid cycle.
- out_valid  out  1  one beat per character.
- out_char  out  3  character index 0..7, ascending order.
- out_len  out  3  code length, 1..7.
- out_code  out  7  code bits; bit out_len-1 is the root-level bit; bits at or above out_len are 0.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - All outputs are 0, except sort_character (all 4'hF) and sort_weight (all 5'h1F).
  - FSM goes to IDLE; node tables and counters are cleared.
  - Reset in any state (including mid-merge) aborts the frame; no partial output is produced.
- Weight range: upstream guarantees the sum of the 8 weights is at most 31, so merged weights fit 5 bits. No saturation logic.
- Node table:
  - 15 entries. Ids 0..7 are leaves; ids 8..14 are internal nodes created in rounds 0..6.
  - Each entry holds weight[4:0] and member mask[7:0].
  - Per character: code[6:0] and len[2:0].
- Active list: n entries, n = 8..2.
  - Slot s < n drives its node id and weight onto the sort ports.
  - Slots s >= n drive the pad entry: id 4'hF, weight 5'h1F.
  - The sorter is stable (it swaps only on strictly greater weight), so lower slots win ties.
- FSM: IDLE -> LOAD -> SORT -> MERGE -> (SORT | OUT) -> IDLE.
  - IDLE:
    - On in_valid, capture weight 0; busy = 1; go to LOAD.
  - LOAD:
    - Capture weights 1..7. Active list = ids 0..7 in slots 0..7; n = 8.
    - If in_valid drops before 8 samples: discard the frame, busy = 0, return to IDLE.
  - SORT (1 cycle):
    - Sort ports are driven from the registered active list.
    - Register sorted_character[4n-1:0] as the ordered list.
  - MERGE (1 cycle). Let a = ordered slot 0 and b = ordered slot 1.
    - New node id = 8 + round; weight = w(a) + w(b); mask = mask(a) | mask(b).
    - For every character in mask(a): code[len] = 0, len += 1.
    - For every character in mask(b): code[len] = 1, len += 1.
    - New active list = ordered slots 2..n-1, then the new node in the last slot, so an existing node wins a tie against the new node.
    - n -= 1.
    - After round 6, go to OUT; otherwise go to SORT.
  - OUT (8 cycles):
    - out_valid = 1; out_char = 0..7, one character per cycle.
    - busy drops with the last beat; return to IDLE.
- Latency: the first out_valid comes 15 cycles after the last in_valid cycle (1 LOAD-to-SORT cycle + 7 rounds x 2 cycles).
- in_valid while busy outside LOAD is ignored.
- Zero weights are legal and sort like any other value.

Optional Feature:
- Macro: HUFF_OUT_READY_EN.
- Defined:
  - Adds input port out_ready (1 bit).
  - In OUT, the beat advances only on out_valid && out_ready.
  - out_char, out_len and out_code hold stable while the beat is stalled.
  - busy stays high until the last accepted beat.
- Undefined: no out_ready port; OUT runs exactly 8 consecutive cycles.

Test Plan:
- All 8 weights = 3:
  - Every out_len = 3.
  - The 8 out_code values are a permutation of 0..7.
  - out_valid first rises 15 cycles after the last in_valid.
- Weights c0..c7 = 1, 2, 4, 8, 16, 0, 0, 0 -> (len, code):
  - c4 = (1, 1), c3 = (2, 01), c2 = (3, 001), c1 = (4, 0001), c0 = (5, 00001).
  - c7 = (6, 000000), c5 = (7, 0000010), c6 = (7, 0000011).
- in_valid held for 5 cycles then dropped:
  - No out_valid; busy returns to 0 the next cycle.
  - A following full frame of all 3s produces the first test's result.
- rst_n low for 1 cycle during round 3 MERGE:
  - Next cycle all outputs are at reset values; no out_valid.
  - A following frame of 1, 2, 4, 8, 16, 0, 0, 0 produces the second test's result.
- in_valid pulsed during SORT/MERGE/OUT: ignored; the current frame's outputs are unchanged.
- With HUFF_OUT_READY_EN defined, out_ready low on beat 3 for 4 cycles: out_char holds at 3 with stable len and code, then beats 3..7 complete.

Source files
------------

// File: rtl/huff_tree_ctrl.sv
// ============================================================================
//  Module   : huff_tree_ctrl
//  Brief    : Sequential Huffman tree builder driving an external 8-slot
//             stable weight sorter. Captures 8 weights, runs 7 merge rounds
//             (SORT + MERGE each), then emits code length / code per char.
//  Option   : HUFF_OUT_READY_EN adds an out_ready handshake on the output beats.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module huff_tree_ctrl #(
    parameter int NUM_CHAR = 8,
    parameter int W_WIDTH  = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [W_WIDTH-1:0]            in_weight,
    output logic [4*NUM_CHAR-1:0]         sort_character,
    output logic [W_WIDTH*NUM_CHAR-1:0]   sort_weight,
    input  logic [4*NUM_CHAR-1:0]         sorted_character,
`ifdef HUFF_OUT_READY_EN
    input  logic                          out_ready,
`endif
    output logic                          busy,
    output logic                          out_valid,
    output logic [2:0]                    out_char,
    output logic [2:0]                    out_len,
    output logic [6:0]                    out_code
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SORT  = 3'd2;
    localparam logic [2:0] MERGE = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    logic [2:0] state;
    logic [2:0] ld_cnt;
    logic [2:0] round;
    logic [2:0] beat;
    logic [3:0] n;                    // active list length, 0 when no frame

    logic [3:0] act    [0:7];         // active list of node ids
    logic [3:0] ord    [0:7];         // sorter result registered in SORT
    logic [4:0] node_w [0:14];
    logic [7:0] node_m [0:14];        // leaf characters below each node
    logic [6:0] code   [0:7];
    logic [2:0] len    [0:7];

    logic [3:0] a_id;
    logic [3:0] b_id;
    logic [3:0] new_id;
    logic [7:0] a_mask;
    logic [7:0] b_mask;
    logic [2:0] last_slot;
    logic       beat_ok;

    assign a_id      = ord[0];
    assign b_id      = ord[1];
    assign new_id    = {1'b1, round};
    assign a_mask    = node_m[a_id];
    assign b_mask    = node_m[b_id];
    assign last_slot = 3'(n - 4'd2);

`ifdef HUFF_OUT_READY_EN
    assign beat_ok = out_ready;
`else
    assign beat_ok = 1'b1;
`endif

    // Sort ports: live slots from the active list, remaining slots padded
    always_comb begin
        sort_character = '1;
        sort_weight    = '1;
        for (int s = 0; s < 8; s++) begin
            if (4'(s) < n) begin
                sort_character[4*s +: 4] = act[s];
                sort_weight[5*s +: 5]    = node_w[act[s]];
            end
        end
    end

    // Output beat decode; everything reads zero outside OUT
    always_comb begin
        out_valid = (state == OUT);
        out_char  = 3'd0;
        out_len   = 3'd0;
        out_code  = 7'd0;
        if (out_valid) begin
            out_char = beat;
            out_len  = len[beat];
            out_code = code[beat];
        end
    end

    // busy covers the first in_valid cycle while still in IDLE
    assign busy = (state != IDLE) || in_valid;

    // Frame capture, merge rounds and output sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ld_cnt <= 3'd0;
            round  <= 3'd0;
            beat   <= 3'd0;
            n      <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                act[i]  <= 4'd0;
                ord[i]  <= 4'd0;
                code[i] <= 7'd0;
                len[i]  <= 3'd0;
            end
            for (int i = 0; i < 15; i++) begin
                node_w[i] <= 5'd0;
                node_m[i] <= 8'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        node_w[0] <= in_weight;
                        ld_cnt    <= 3'd1;
                        for (int c = 0; c < 8; c++) begin
                            code[c] <= 7'd0;
                            len[c]  <= 3'd0;
                        end
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!in_valid) begin
                        state <= IDLE;
                    end else begin
                        node_w[{1'b0, ld_cnt}] <= in_weight;
                        if (ld_cnt == 3'd7) begin
                            for (int i = 0; i < 8; i++) begin
                                act[i]    <= 4'(i);
                                node_m[i] <= 8'd1 << i;
                            end
                            n     <= 4'd8;
                            round <= 3'd0;
                            state <= SORT;
                        end else begin
                            ld_cnt <= ld_cnt + 3'd1;
                        end
                    end
                end
                SORT: begin
                    for (int s = 0; s < 8; s++) begin
                        ord[s] <= sorted_character[4*s +: 4];
                    end
                    state <= MERGE;
                end
                MERGE: begin
                    node_w[new_id] <= node_w[a_id] + node_w[b_id];
                    node_m[new_id] <= a_mask | b_mask;
                    // a side appends a 0 bit (already clear), b side a 1 bit
                    for (int c = 0; c < 8; c++) begin
                        if (a_mask[c]) begin
                            len[c] <= len[c] + 3'd1;
                        end else if (b_mask[c]) begin
                            code[c] <= code[c] | (7'd1 << len[c]);
                            len[c]  <= len[c] + 3'd1;
                        end
                    end
                    // survivors shift down; new node goes last so it loses ties
                    for (int s = 0; s < 6; s++) begin
                        if (4'(s) + 4'd2 < n) begin
                            act[s] <= ord[s+2];
                        end
                    end
                    act[last_slot] <= new_id;
                    round <= round + 3'd1;
                    if (round == 3'd6) begin
                        n     <= 4'd0;
                        beat  <= 3'd0;
                        state <= OUT;
                    end else begin
                        n     <= n - 4'd1;
                        state <= SORT;
                    end
                end
                OUT: begin
                    if (beat_ok) begin
                        if (beat == 3'd7) begin
                            beat  <= 3'd0;
                            state <= IDLE;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
